// File: rtl/sw_ctrlr_debounce.sv
// N-channel switch front end: synchroniser, per-channel debouncer, sticky
// edge events with overrun tracking, and a maskable registered level IRQ.
module sw_ctrlr_debounce #(
   parameter int N               = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_irq,
   input  logic [N-1:0]     sw_mask,
   input  logic [2*N-1:0]   edge_mode,
   input  logic [N-1:0]     sw_event_ack,
   output logic [N-1:0]     sw_event,
   output logic [N-1:0]     sw_overrun,
   output logic [N-1:0]     sw_state,
   output logic             irq,
   input  logic [N-1:0]     SW
);

   localparam int PW = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [PW-1:0] prime_cnt_reg;
   logic          primed_reg;
   logic          prime_done;
   logic          irq_reg;

   // Wait for the synchroniser to fill before adopting its output as the
   // initial debounced level, so reset release never looks like an edge.
   assign prime_done = ~primed_reg & (prime_cnt_reg == PW'(SYNC_STAGES));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_cnt_reg <= '0;
         primed_reg    <= 1'b0;
      end else if (!primed_reg) begin
         if (prime_done)
            primed_reg <= 1'b1;
         else
            prime_cnt_reg <= prime_cnt_reg + PW'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_reg;
         logic [CNT_W-1:0]       cnt_reg;
         logic                   state_reg;
         logic                   event_reg;
         logic                   overrun_reg;
         logic                   s;
         logic                   commit;
         logic                   qual;

         assign s      = sync_reg[SYNC_STAGES-1];
         assign commit = primed_reg & (s != state_reg) & (cnt_reg == CNT_LAST);
         assign qual   = commit & ((s & edge_mode[2*gi]) | (~s & edge_mode[2*gi+1]));

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               sync_reg <= '0;
            else
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], SW[gi]};
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg     <= '0;
               state_reg   <= 1'b0;
               event_reg   <= 1'b0;
               overrun_reg <= 1'b0;
            end else begin
               if (!primed_reg) begin
                  cnt_reg <= '0;
                  if (prime_done)
                     state_reg <= s;
               end else if (s == state_reg) begin
                  cnt_reg <= '0;
               end else if (commit) begin
                  state_reg <= s;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end

               // A new qualified edge wins over a simultaneous acknowledge.
               if (qual)
                  event_reg <= 1'b1;
               else if (sw_event_ack[gi])
                  event_reg <= 1'b0;

               if (qual & event_reg & ~sw_event_ack[gi])
                  overrun_reg <= 1'b1;
               else if (sw_event_ack[gi])
                  overrun_reg <= 1'b0;
            end
         end

         assign sw_state[gi]   = state_reg;
         assign sw_event[gi]   = event_reg;
         assign sw_overrun[gi] = overrun_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         irq_reg <= 1'b0;
      else
         irq_reg <= enable_irq & (|(sw_event & sw_mask));
   end

   assign irq = irq_reg;

endmodule

// File: tb/tb_sw_ctrlr_debounce.sv
// Directed bench for sw_ctrlr_debounce with N=4, two sync stages and a
// four-cycle debounce window; expected values are worked out by hand.
module tb_sw_ctrlr_debounce;

   localparam int N = 4;

   logic           clk;
   logic           reset;
   logic           enable_irq;
   logic [N-1:0]   sw_mask;
   logic [2*N-1:0] edge_mode;
   logic [N-1:0]   sw_event_ack;
   logic [N-1:0]   sw_event;
   logic [N-1:0]   sw_overrun;
   logic [N-1:0]   sw_state;
   logic           irq;
   logic [N-1:0]   SW;

   int n_compared = 0;
   int n_mismatched = 0;

   sw_ctrlr_debounce #(
      .N               (N),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable_irq   (enable_irq),
      .sw_mask      (sw_mask),
      .edge_mode    (edge_mode),
      .sw_event_ack (sw_event_ack),
      .sw_event     (sw_event),
      .sw_overrun   (sw_overrun),
      .sw_state     (sw_state),
      .irq          (irq),
      .SW           (SW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset        = 1'b1;
      enable_irq   = 1'b1;
      sw_mask      = 4'hF;
      edge_mode    = 8'hFF;
      sw_event_ack = 4'h0;
      SW           = 4'b0101;

      step(2);
      check("rst_state", 8'(sw_state), 8'h0);
      check("rst_event", 8'(sw_event), 8'h0);
      check("rst_ovr",   8'(sw_overrun), 8'h0);
      check("rst_irq",   8'(irq), 8'h0);

      reset = 1'b0;
      step(2);
      check("prime_wait_state", 8'(sw_state), 8'h0);
      step(1);
      check("primed_state", 8'(sw_state), 8'h5);
      check("primed_event", 8'(sw_event), 8'h0);
      step(1);
      check("primed_irq", 8'(irq), 8'h0);

      // ch0 fall
      SW = 4'b0100;
      step(5);
      check("ch0_fall_hold", 8'(sw_state), 8'h5);
      step(1);
      check("ch0_fall_state", 8'(sw_state), 8'h4);
      check("ch0_fall_event", 8'(sw_event), 8'h1);
      check("ch0_fall_irq_lag", 8'(irq), 8'h0);
      step(1);
      check("ch0_fall_irq", 8'(irq), 8'h1);
      sw_event_ack = 4'h1;
      step(1);
      sw_event_ack = 4'h0;
      check("ack_event", 8'(sw_event), 8'h0);
      check("ack_irq_lag", 8'(irq), 8'h1);
      step(1);
      check("ack_irq", 8'(irq), 8'h0);

      // ch0 rise: 6th edge commit, irq one later
      SW = 4'b0101;
      step(5);
      check("ch0_rise_hold", 8'(sw_state), 8'h4);
      step(1);
      check("ch0_rise_state", 8'(sw_state), 8'h5);
      check("ch0_rise_event", 8'(sw_event), 8'h1);
      check("ch0_rise_irq_lag", 8'(irq), 8'h0);
      step(1);
      check("ch0_rise_irq", 8'(irq), 8'h1);

      // ch1 high for only three cycles
      SW = 4'b0111;
      step(3);
      SW = 4'b0101;
      step(8);
      check("glitch_state", 8'(sw_state), 8'h5);
      check("glitch_event", 8'(sw_event), 8'h1);

      // second qualified edge while pending
      SW = 4'b0100;
      step(6);
      check("ovr_state", 8'(sw_state), 8'h4);
      check("ovr_event", 8'(sw_event), 8'h1);
      check("ovr_flag",  8'(sw_overrun), 8'h1);

      // ack in the commit cycle: event re-set, overrun cleared
      SW = 4'b0101;
      step(5);
      sw_event_ack = 4'h1;
      step(1);
      sw_event_ack = 4'h0;
      check("ackq_state", 8'(sw_state), 8'h5);
      check("ackq_event", 8'(sw_event), 8'h1);
      check("ackq_ovr",   8'(sw_overrun), 8'h0);
      sw_event_ack = 4'h1;
      step(1);
      sw_event_ack = 4'h0;
      check("clr_event", 8'(sw_event), 8'h0);
      step(1);
      check("clr_irq", 8'(irq), 8'h0);

      // ch2 rise-only
      edge_mode = 8'hDF;
      SW = 4'b0001;
      step(6);
      check("mode_fall_state", 8'(sw_state), 8'h1);
      check("mode_fall_event", 8'(sw_event), 8'h0);
      SW = 4'b0101;
      step(6);
      check("mode_rise_state", 8'(sw_state), 8'h5);
      check("mode_rise_event", 8'(sw_event), 8'h4);
      step(1);
      check("mode_rise_irq", 8'(irq), 8'h1);
      sw_event_ack = 4'h4;
      step(1);
      sw_event_ack = 4'h0;
      edge_mode = 8'hFF;
      step(1);
      check("mode_clr_irq", 8'(irq), 8'h0);
      check("mode_chg_event", 8'(sw_event), 8'h0);

      // masked event latches, irq follows mask and enable
      sw_mask = 4'h0;
      SW = 4'b1101;
      step(6);
      check("mask_state", 8'(sw_state), 8'hD);
      check("mask_event", 8'(sw_event), 8'h8);
      step(1);
      check("mask_irq_off", 8'(irq), 8'h0);
      sw_mask = 4'h8;
      step(1);
      check("mask_irq_on", 8'(irq), 8'h1);
      enable_irq = 1'b0;
      step(1);
      check("disable_irq", 8'(irq), 8'h0);

      // reset during a ch3 debounce, then re-prime
      enable_irq = 1'b1;
      SW = 4'b0101;
      step(3);
      reset = 1'b1;
      step(1);
      check("midrst_state", 8'(sw_state), 8'h0);
      check("midrst_event", 8'(sw_event), 8'h0);
      reset = 1'b0;
      step(2);
      check("reprime_wait", 8'(sw_state), 8'h0);
      step(1);
      check("reprime_state", 8'(sw_state), 8'h5);
      check("reprime_event", 8'(sw_event), 8'h0);
      step(1);
      check("reprime_irq", 8'(irq), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
